// File: rtl/lfsr_counter_gen.sv
// Parametrised Fibonacci LFSR terminal counter with seed, one-shot/auto-reload mode.
// Optional binary step counter output enabled by defining LFSR_STEP_CNT_EN.
module lfsr_counter_gen #(
  parameter int WIDTH       = 4,
  parameter int SEED        = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             count_en,
  input  logic [WIDTH-1:0] count_to,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] state
`ifdef LFSR_STEP_CNT_EN
  ,
  output logic [WIDTH-1:0] step_cnt
`endif
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  if (WIDTH < 3 || WIDTH > 8) begin : g_bad_width
    $error("lfsr_counter_gen: WIDTH must be 3..8");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("lfsr_counter_gen: SEED masked to WIDTH must be nonzero");
  end

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_target;
  logic             r_done;
  logic             r_busy;
  logic             r_err;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_fire;
  logic             w_hit;

  // Maximal-length taps, one per supported width
  if (WIDTH == 3) begin : g_fb3
    assign w_fb = r_state[2] ^ r_state[1];
  end else if (WIDTH == 4) begin : g_fb4
    assign w_fb = r_state[3] ^ r_state[2];
  end else if (WIDTH == 5) begin : g_fb5
    assign w_fb = r_state[4] ^ r_state[2];
  end else if (WIDTH == 6) begin : g_fb6
    assign w_fb = r_state[5] ^ r_state[4];
  end else if (WIDTH == 7) begin : g_fb7
    assign w_fb = r_state[6] ^ r_state[5];
  end else begin : g_fb8
    assign w_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
  end

  assign w_next = {r_state[WIDTH-2:0], w_fb};
  assign w_fire = count_en & r_busy;
  assign w_hit  = (w_next == r_target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SEED_W;
      r_target <= SEED_W;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else if (load) begin
      r_state  <= SEED_W;
      r_target <= count_to;
      r_done   <= 1'b0;
      r_busy   <= (count_to != '0);
      r_err    <= (count_to == '0);
    end else if (w_fire) begin
      r_done <= w_hit;
      if (w_hit && AUTO_RELOAD != 0) begin
        r_state <= SEED_W;
      end else begin
        r_state <= w_next;
      end
      if (w_hit && AUTO_RELOAD == 0) begin
        r_busy <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

`ifdef LFSR_STEP_CNT_EN
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] w_step_inc;

  assign w_step_inc = (r_step == '1) ? r_step : r_step + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step <= '0;
    end else if (load) begin
      r_step <= '0;
    end else if (w_fire) begin
      if (w_hit && AUTO_RELOAD != 0) begin
        r_step <= '0;
      end else begin
        r_step <= w_step_inc;
      end
    end
  end

  assign step_cnt = r_step;
`endif

  assign done  = r_done;
  assign busy  = r_busy;
  assign err   = r_err;
  assign state = r_state;

endmodule
